// File: rtl/bitstream_extractor_pkg.sv
// bitstream_extractor shared definitions
// width helpers and error-flag bit positions
package bitstream_extractor_pkg;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    function automatic int avail_w(input int buffer_width);
        return log2(buffer_width) + 1;
    endfunction

    function automatic int pop_w(input int width_out);
        return log2(width_out) + 1;
    endfunction

    function automatic int count_w(input int fifo_depth);
        return log2(fifo_depth) + 1;
    endfunction

    function automatic int pos_w(input int align_bits);
        return (log2(align_bits) > 0) ? log2(align_bits) : 1;
    endfunction

    localparam int ERR_W   = 2;
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

endpackage

// File: rtl/bitstream_extractor_if.sv
// bitstream_extractor producer/consumer bus
// master drives words and pops, slave returns window and status
interface bitstream_extractor_if
    import bitstream_extractor_pkg::*;
#(
    parameter int WIDTH_IN     = 64,
    parameter int WIDTH_OUT    = 64,
    parameter int FIFO_DEPTH   = 32,
    parameter int BUFFER_WIDTH = WIDTH_OUT + WIDTH_IN
);
    localparam int AVAIL_W = avail_w(BUFFER_WIDTH);
    localparam int POP_W   = pop_w(WIDTH_OUT);
    localparam int COUNT_W = count_w(FIFO_DEPTH);

    logic                 push;
    logic [WIDTH_IN-1:0]  d;
    logic [POP_W-1:0]     pop;
    logic                 align;
    logic                 flush;
    logic [WIDTH_OUT-1:0] q;
    logic [AVAIL_W-1:0]   avail;
    logic                 ready;
    logic                 full;
    logic                 half_full;
    logic                 almost_full;
    logic                 almost_empty;
    logic [COUNT_W-1:0]   fifo_count;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output push, d, pop, align, flush,
        input  q, avail, ready, full, half_full, almost_full,
        input  almost_empty, fifo_count, err_overflow, err_underflow
    );

    modport slave (
        input  push, d, pop, align, flush,
        output q, avail, ready, full, half_full, almost_full,
        output almost_empty, fifo_count, err_overflow, err_underflow
    );

endinterface

// File: rtl/bitstream_extractor_window.sv
// bit window: LSB-first shift register with avail and stream position
// applies pop, then align, then appends one FIFO word when it fits
module bitstream_extractor_window
    import bitstream_extractor_pkg::*;
#(
    parameter int WIDTH_IN     = 64,
    parameter int WIDTH_OUT    = 64,
    parameter int ALIGN_BITS   = 8,
    parameter int BUFFER_WIDTH = WIDTH_OUT + WIDTH_IN,
    parameter int POP_W        = pop_w(WIDTH_OUT),
    parameter int AW           = avail_w(BUFFER_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [POP_W-1:0]     pop,
    input  logic                 align,
    input  logic                 load,
    input  logic [WIDTH_IN-1:0]  load_data,
    output logic [WIDTH_OUT-1:0] q,
    output logic [AW-1:0]        avail,
    output logic                 room,
    output logic                 underflow
);
    localparam int PW = pos_w(ALIGN_BITS);
    localparam logic [AW-1:0] MASK = AW'(ALIGN_BITS - 1);
    localparam logic [AW-1:0] GRAN = AW'(ALIGN_BITS);
    localparam logic [AW-1:0] FIT  = AW'(BUFFER_WIDTH - WIDTH_IN);

    logic [BUFFER_WIDTH-1:0] win, win_d, w1, w2, ext;
    logic [AW-1:0]           avail_r, avail_d;
    logic [PW-1:0]           pos_r, pos_d;
    logic [AW-1:0]           n, a1, a2, p0, p1, p2, k, cut;
    logic                    pop_ok, short;

    // pop first, align on the updated position, then append at the new tail
    always_comb begin
        n      = AW'(pop);
        p0     = AW'(pos_r);
        pop_ok = n <= avail_r;
        a1     = avail_r;
        w1     = win;
        p1     = p0;
        if (pop_ok) begin
            a1 = avail_r - n;
            w1 = win >> n;
            p1 = (p0 + n) & MASK;
        end
        k     = (GRAN - p1) & MASK;
        short = align && (k > a1);
        cut   = '0;
        if (align) cut = short ? a1 : k;
        a2    = a1 - cut;
        w2    = w1 >> cut;
        p2    = (p1 + cut) & MASK;
        room  = a2 <= FIT;
        underflow = !flush && (!pop_ok || short);
        ext     = BUFFER_WIDTH'(load_data);
        win_d   = w2;
        avail_d = a2;
        pos_d   = p2[PW-1:0];
        if (load) begin
            win_d   = w2 | (ext << a2);
            avail_d = a2 + AW'(WIDTH_IN);
        end
        if (flush) begin
            win_d   = '0;
            avail_d = '0;
            pos_d   = '0;
        end
    end

    // window, fill level and stream position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            win     <= '0;
            avail_r <= '0;
            pos_r   <= '0;
        end else begin
            win     <= win_d;
            avail_r <= avail_d;
            pos_r   <= pos_d;
        end
    end

    assign q     = win[WIDTH_OUT-1:0];
    assign avail = avail_r;

endmodule

// File: rtl/bitstream_extractor.sv
// bitstream_extractor top: word FIFO feeding a bit window
// owns FIFO pointers, status outputs and sticky error flags
module bitstream_extractor
    import bitstream_extractor_pkg::*;
#(
    parameter int WIDTH_IN           = 64,
    parameter int WIDTH_OUT          = 64,
    parameter int FIFO_DEPTH         = 32,
    parameter int ALMOST_EMPTY_COUNT = 4,
    parameter int ALMOST_FULL_COUNT  = 1,
    parameter int ALIGN_BITS         = 8,
    parameter int BUFFER_WIDTH       = WIDTH_OUT + WIDTH_IN
) (
    input logic                 clk,
    input logic                 rst,
    bitstream_extractor_if.slave bus
);
    localparam int AW    = avail_w(BUFFER_WIDTH);
    localparam int POP_W = pop_w(WIDTH_OUT);
    localparam int CW    = count_w(FIFO_DEPTH);
    localparam int PTR_W = log2(FIFO_DEPTH);

    logic [WIDTH_IN-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CW-1:0]       count;
    logic [ERR_W-1:0]    err;
    logic                full_w, wr, rd, room, win_unf;
    logic [AW-1:0]       avail;

    assign full_w = count == CW'(FIFO_DEPTH);
    assign wr     = bus.push && !bus.flush && !full_w;
    assign rd     = (count != '0) && room && !bus.flush;

    // word storage; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (wr) mem[tail] <= bus.d;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(wr);
            head  <= head + PTR_W'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else begin
            if (bus.push && !bus.flush && full_w) err[ERR_OVF] <= 1'b1;
            if (win_unf) err[ERR_UNF] <= 1'b1;
        end
    end

    bitstream_extractor_window #(
        .WIDTH_IN     (WIDTH_IN),
        .WIDTH_OUT    (WIDTH_OUT),
        .ALIGN_BITS   (ALIGN_BITS),
        .BUFFER_WIDTH (BUFFER_WIDTH),
        .POP_W        (POP_W),
        .AW           (AW)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .pop       (bus.pop),
        .align     (bus.align),
        .load      (rd),
        .load_data (mem[head]),
        .q         (bus.q),
        .avail     (avail),
        .room      (room),
        .underflow (win_unf)
    );

    assign bus.avail         = avail;
    assign bus.ready         = avail >= AW'(WIDTH_OUT);
    assign bus.fifo_count    = count;
    assign bus.full          = full_w;
    assign bus.half_full     = count >= CW'(FIFO_DEPTH / 2);
    assign bus.almost_full   = count >= CW'(FIFO_DEPTH - ALMOST_FULL_COUNT);
    assign bus.almost_empty  = count <= CW'(ALMOST_EMPTY_COUNT);
    assign bus.err_overflow  = err[ERR_OVF];
    assign bus.err_underflow = err[ERR_UNF];

endmodule

// File: tb/tb_bitstream_extractor.sv
// bitstream_extractor bench: directed scenarios then random traffic
// reference model keeps the stream as a bit queue and FIFO as a word queue
module tb_bitstream_extractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitstream_extractor_if #(
        .WIDTH_IN(32), .WIDTH_OUT(16), .FIFO_DEPTH(8), .BUFFER_WIDTH(48)
    ) bus ();

    bitstream_extractor #(
        .WIDTH_IN(32), .WIDTH_OUT(16), .FIFO_DEPTH(8),
        .ALMOST_EMPTY_COUNT(4), .ALMOST_FULL_COUNT(1),
        .ALIGN_BITS(8), .BUFFER_WIDTH(48)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    bit          wq[$];
    logic [31:0] fq[$];
    int          pos;
    bit          m_ovf, m_unf;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int n, k, pre;
        logic [31:0] w;
        if (rst) begin
            wq.delete(); fq.delete(); pos = 0; m_ovf = 0; m_unf = 0;
        end else if (bus.flush) begin
            wq.delete(); fq.delete(); pos = 0;
        end else begin
            pre = fq.size();
            n = int'(bus.pop);
            if (n <= wq.size()) begin
                repeat (n) void'(wq.pop_front());
                pos = (pos + n) % 8;
            end else begin
                m_unf = 1;
            end
            if (bus.align) begin
                k = (8 - pos) % 8;
                if (k > wq.size()) begin
                    pos = (pos + wq.size()) % 8;
                    wq.delete();
                    m_unf = 1;
                end else begin
                    repeat (k) void'(wq.pop_front());
                    pos = (pos + k) % 8;
                end
            end
            if (pre > 0 && wq.size() + 32 <= 48) begin
                w = fq.pop_front();
                for (int i = 0; i < 32; i++) wq.push_back(w[i]);
            end
            if (bus.push) begin
                if (pre == 8) m_ovf = 1;
                else fq.push_back(bus.d);
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] eq;
        int c;
        eq = '0;
        for (int i = 0; i < 16 && i < wq.size(); i++) eq[i] = wq[i];
        c = fq.size();
        check("q", 64'(bus.q), 64'(eq));
        check("avail", 64'(bus.avail), 64'(wq.size()));
        check("ready", 64'(bus.ready), 64'(wq.size() >= 16));
        check("count", 64'(bus.fifo_count), 64'(c));
        check("full", 64'(bus.full), 64'(c == 8));
        check("half_full", 64'(bus.half_full), 64'(c >= 4));
        check("almost_full", 64'(bus.almost_full), 64'(c >= 7));
        check("almost_empty", 64'(bus.almost_empty), 64'(c <= 4));
        check("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
        check("err_underflow", 64'(bus.err_underflow), 64'(m_unf));
    endtask

    task automatic idle_inputs();
        bus.push = 0; bus.d = '0; bus.pop = '0;
        bus.align = 0; bus.flush = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic step(input bit p, input logic [31:0] dv, input int n,
                        input bit al, input bit fl);
        bus.push = p; bus.d = dv; bus.pop = 5'(n);
        bus.align = al; bus.flush = fl;
        cycle();
        idle_inputs();
    endtask

    initial begin
        int n;
        bit found;
        rst = 1;
        idle_inputs();
        cycle();
        rst = 0;
        check("rst_avail", 64'(bus.avail), 64'd0);
        check("rst_q", 64'(bus.q), 64'd0);
        check("rst_count", 64'(bus.fifo_count), 64'd0);

        // single word, pop, align, drain
        step(1, 32'hDEADBEEF, 0, 0, 0);
        check("t1_lat1", 64'(bus.avail), 64'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t1_q", 64'(bus.q), 64'hBEEF);
        check("t1_avail", 64'(bus.avail), 64'd32);
        check("t1_ready", 64'(bus.ready), 64'd1);
        step(0, 0, 4, 0, 0);
        check("t1_pop_q", 64'(bus.q), 64'hDBEE);
        check("t1_pop_avail", 64'(bus.avail), 64'd28);
        step(0, 0, 0, 1, 0);
        check("t2_align_q", 64'(bus.q), 64'hADBE);
        check("t2_align_avail", 64'(bus.avail), 64'd24);
        step(0, 0, 16, 0, 0);
        check("t2_pop16_q", 64'(bus.q), 64'h00DE);
        check("t2_ready", 64'(bus.ready), 64'd0);
        step(0, 0, 9, 0, 0);
        check("t3_unf", 64'(bus.err_underflow), 64'd1);
        check("t3_avail", 64'(bus.avail), 64'd8);
        check("t3_q", 64'(bus.q), 64'h00DE);
        step(0, 0, 8, 0, 0);
        check("t3_drain", 64'(bus.avail), 64'd0);

        // fill until overflow
        for (int i = 0; i < 10; i++) begin
            step(1, $urandom, 0, 0, 0);
            if (i == 8) check("t4_full", 64'(bus.full), 64'd1);
            if (i == 9) check("t4_ovf", 64'(bus.err_overflow), 64'd1);
        end
        check("t4_avail", 64'(bus.avail), 64'd32);
        check("t4_count", 64'(bus.fifo_count), 64'd8);

        // simultaneous push and read at count 3, then flush with push
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (fq.size() == 3 && wq.size() >= 16 && wq.size() <= 32) begin
                step(1, $urandom, 16, 0, 0);
                check("t5_count_hold", 64'(bus.fifo_count), 64'd3);
                found = 1;
            end else begin
                step(0, 0, (wq.size() >= 16) ? 16 : 0, 0, 0);
            end
        end
        check("t5_reached", 64'(found), 64'd1);
        step(1, 32'hCAFEF00D, 0, 0, 1);
        check("t5_flush_avail", 64'(bus.avail), 64'd0);
        check("t5_flush_count", 64'(bus.fifo_count), 64'd0);
        check("t5_flush_ovf", 64'(bus.err_overflow), 64'd1);
        check("t5_flush_unf", 64'(bus.err_underflow), 64'd1);

        // reset mid-stream
        step(1, 32'hA5A5A5A5, 0, 0, 0);
        step(1, 32'h5A5A5A5A, 0, 0, 0);
        rst = 1;
        cycle();
        rst = 0;
        check("t6_ovf", 64'(bus.err_overflow), 64'd0);
        check("t6_unf", 64'(bus.err_underflow), 64'd0);
        check("t6_avail", 64'(bus.avail), 64'd0);
        check("t6_count", 64'(bus.fifo_count), 64'd0);
        step(1, 32'h12345678, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("t6_q", 64'(bus.q), 64'h5678);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 16);
            if (($urandom % 5) != 0 && n > wq.size()) n = wq.size();
            rst = (($urandom % 300) == 0);
            step(($urandom % 2) == 1, $urandom, n,
                 ($urandom % 16) == 0, ($urandom % 64) == 0);
            rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
